// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: shared definitions for the pipelined ALU.
//   - DEFAULT_WIDTH : default operand/result width
//   - op_e          : 3-bit opcode encoding
//   - FLAG_*        : bit positions inside the 4-bit flags vector
package pipe_alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XOR  = 3'b110,
        OP_XNOR = 3'b111
    } op_e;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/pipe_alu_if.sv
// pipe_alu_if: valid/ready operation and result bus of pipe_alu.
//   upstream  : in_valid, in_ready, op, a, b, use_acc, acc_wr
//   downstream: out_valid, out_ready, result, flags
//   status    : acc (current accumulator)
// slave modport is used by the ALU, master by whoever drives it.
interface pipe_alu_if #(
    parameter int unsigned WIDTH = pipe_alu_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic             acc_wr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH-1:0] acc;

    modport slave (
        input  in_valid, op, a, b, use_acc, acc_wr, out_ready,
        output in_ready, out_valid, result, flags, acc
    );

    modport master (
        output in_valid, op, a, b, use_acc, acc_wr, out_ready,
        input  in_ready, out_valid, result, flags, acc
    );
endinterface

// File: rtl/pipe_alu_alu_core.sv
// alu_core: purely combinational ALU.
//   op     : opcode (op_e encoding)
//   a, b   : operands
//   result : operation result
//   flags  : {carry, overflow, negative, zero}
module alu_core
    import pipe_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    // Extended subtraction: the top bit is the unsigned borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: two-stage pipelined ALU with an internal accumulator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_alu_if slave (operation in, result/flags out, acc)
// S1 holds the accepted operation; the ALU evaluates on the S1->S2
// transfer and S2 holds result/flags until downstream takes them.
module pipe_alu
    import pipe_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    pipe_alu_if.slave bus
);

    logic             s1_full_q, s1_full_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_use_acc_q, s1_use_acc_d;
    logic             s1_acc_wr_q, s1_acc_wr_d;
    logic             s2_full_q, s2_full_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    // The accumulator is read at the S1->S2 transfer, so any older
    // acc_wr op has already written it back: no forwarding needed.
    assign eff_a    = s1_use_acc_q ? acc_q : s1_a_q;
    assign s2_adv   = s1_full_q && (!s2_full_q || bus.out_ready);
    assign in_ready = !rst && (!s1_full_q || s2_adv);
    assign accept   = bus.in_valid && in_ready;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op     (s1_op_q),
        .a      (eff_a),
        .b      (s1_b_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        s1_full_d    = s1_full_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_use_acc_d = s1_use_acc_q;
        s1_acc_wr_d  = s1_acc_wr_q;
        s2_full_d    = s2_full_q;
        result_d     = result_q;
        flags_d      = flags_q;
        acc_d        = acc_q;

        if (s2_adv) begin
            s2_full_d = 1'b1;
            result_d  = alu_result;
            flags_d   = alu_flags;
            if (s1_acc_wr_q) begin
                acc_d = alu_result;
            end
        end else if (s2_full_q && bus.out_ready) begin
            s2_full_d = 1'b0;
        end

        if (accept) begin
            s1_full_d    = 1'b1;
            s1_op_d      = bus.op;
            s1_a_d       = bus.a;
            s1_b_d       = bus.b;
            s1_use_acc_d = bus.use_acc;
            s1_acc_wr_d  = bus.acc_wr;
        end else if (s2_adv) begin
            s1_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q    <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_use_acc_q <= 1'b0;
            s1_acc_wr_q  <= 1'b0;
            s2_full_q    <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            acc_q        <= '0;
        end else begin
            s1_full_q    <= s1_full_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_use_acc_q <= s1_use_acc_d;
            s1_acc_wr_q  <= s1_acc_wr_d;
            s2_full_q    <= s2_full_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_full_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: scoreboard bench for pipe_alu at WIDTH=8.
module tb_pipe_alu;
    import pipe_alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic [7:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    logic [7:0] macc = '0;

    pipe_alu_if #(.WIDTH(8)) bus ();
    pipe_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ux = x;
        int uy = y;
        int sx = $signed(x);
        int sy = $signed(y);
        int r = 0;
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            3'd0: begin r = ux + uy; c = (r > 255); v = (sx + sy > 127) || (sx + sy < -128); end
            3'd1: begin r = ux - uy; c = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); end
            3'd2: r = int'(x & y);
            3'd3: r = int'(x | y);
            3'd4: r = int'(8'(~(x & y)));
            3'd5: r = int'(8'(~(x | y)));
            3'd6: r = int'(x ^ y);
            default: r = int'(8'(~(x ^ y)));
        endcase
        e.res = r[7:0];
        e.flg = {c, v, e.res[7], (e.res == 8'h00)};
        e.acc = '0;
        return e;
    endfunction

    // Drives one cycle (inputs set at negedge), samples outputs #1 later,
    // pushes the expected result on acceptance, then advances one clock.
    task automatic step(input logic iv, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic aw, input logic ordy,
                        output logic acc_ok, output logic cons, output logic ov, output logic ir,
                        output logic [7:0] r, output logic [3:0] f, output logic [7:0] ac);
        exp_t e;
        bus.in_valid = iv; bus.op = op; bus.a = a; bus.b = b;
        bus.use_acc = ua; bus.acc_wr = aw; bus.out_ready = ordy;
        #1;
        ir = bus.in_ready; ov = bus.out_valid; r = bus.result; f = bus.flags; ac = bus.acc;
        acc_ok = iv && ir;
        cons = ov && ordy;
        if (acc_ok) begin
            e = model(op, ua ? macc : a, b);
            if (aw) macc = e.res;
            e.acc = macc;
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        rst = 1'b1;
        step(1'b1, 3'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
        step(1'b1, 3'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b0 || r !== 8'h00 || f !== 4'h0 || ac !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: ov=%b ir=%b r=%h f=%h acc=%h required 0 0 00 0 00", ov, ir, r, f, ac);
        end
        rst = 1'b0;
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
        checks++;
        if (ir !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", ir);
        end
    endtask

    task automatic test_latency();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        int seen = -1;
        step(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            if (ov && seen < 0) begin
                seen = c;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL latency_data: output with empty scoreboard");
                end else begin
                    exp_t e = sbq.pop_front();
                    if (r !== e.res || f !== e.flg) begin
                        failures++;
                        $display("FAIL add_ff_01: result=%h flags=%b required %h %b", r, f, e.res, e.flg);
                    end
                end
            end
        end
        checks++;
        if (seen != 2) begin
            failures++;
            $display("FAIL latency: out_valid after %0d cycles required 2", seen);
        end
        sbq.delete();
    endtask

    task automatic test_vectors();
        logic [2:0] ops[10] = '{OP_ADD, OP_SUB, OP_SUB, OP_OR, OP_NAND, OP_XNOR, OP_AND, OP_NOR, OP_XOR, OP_ADD};
        logic [7:0] as[10]  = '{8'hFF, 8'h80, 8'h01, 8'hA0, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hAA, 8'h7F};
        logic [7:0] bs[10]  = '{8'h01, 8'h01, 8'h02, 8'h05, 8'hFF, 8'hF0, 8'h3C, 8'h00, 8'h0F, 8'h01};
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        int idx = 0;
        for (int c = 0; c < 100 && (idx < 10 || sbq.size() != 0); c++) begin
            if (idx < 10) step(1'b1, ops[idx], as[idx], bs[idx], 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            else          step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            if (ak) idx++;
            if (cs) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL vec_extra: unexpected result %h", r);
                end else begin
                    exp_t e = sbq.pop_front();
                    if (r !== e.res || f !== e.flg) begin
                        failures++;
                        $display("FAIL vec_result: result=%h flags=%b required %h %b", r, f, e.res, e.flg);
                    end
                end
            end
        end
        checks++;
        if (idx != 10 || sbq.size() != 0) begin
            failures++;
            $display("FAIL vec_drain: issued=%0d pending=%0d required 10 0", idx, sbq.size());
        end
    endtask

    task automatic test_acc_chain();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        int idx = 0;
        int steps = 0;
        int outs = 0;
        int first_out = -1;
        int last_out = -1;
        for (int c = 0; c < 40 && (idx < 3 || sbq.size() != 0); c++) begin
            if (idx == 0)     step(1'b1, OP_ADD, 8'h00, 8'h05, 1'b0, 1'b1, 1'b1, ak, cs, ov, ir, r, f, ac);
            else if (idx < 3) step(1'b1, OP_ADD, 8'hEE, 8'h03, 1'b1, 1'b1, 1'b1, ak, cs, ov, ir, r, f, ac);
            else              step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            if (idx < 3) steps++;
            if (ak) idx++;
            if (cs) begin
                outs++;
                if (first_out < 0) first_out = c;
                last_out = c;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL acc_extra: unexpected result %h", r);
                end else begin
                    exp_t e = sbq.pop_front();
                    if (r !== e.res || f !== e.flg || ac !== e.acc) begin
                        failures++;
                        $display("FAIL acc_result: result=%h flags=%b acc=%h required %h %b %h",
                                 r, f, ac, e.res, e.flg, e.acc);
                    end
                end
            end
        end
        checks++;
        if (steps != 3 || outs != 3 || last_out - first_out != 2) begin
            failures++;
            $display("FAIL acc_bubbles: issue_cycles=%0d outs=%0d span=%0d required 3 3 2",
                     steps, outs, last_out - first_out);
        end
        checks++;
        if (bus.acc !== macc) begin
            failures++;
            $display("FAIL acc_final: acc=%h required %h", bus.acc, macc);
        end
    endtask

    task automatic test_backpressure();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        logic [7:0] held_r; logic [3:0] held_f;
        logic [2:0] ops[3] = '{OP_XOR, OP_SUB, OP_AND};
        logic [7:0] as[3]  = '{8'h3C, 8'h10, 8'hF3};
        logic [7:0] bs[3]  = '{8'h55, 8'h20, 8'h0F};
        int idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) step(1'b1, ops[idx], as[idx], bs[idx], 1'b0, 1'b0, 1'b0, ak, cs, ov, ir, r, f, ac);
            else         step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ak, cs, ov, ir, r, f, ac);
            if (ak) idx++;
            if (c == 2) begin held_r = r; held_f = f; end
            if (c >= 2) begin
                checks++;
                if (ir !== 1'b0 || ov !== 1'b1 || r !== held_r || f !== held_f) begin
                    failures++;
                    $display("FAIL bp_stall: cyc=%0d in_ready=%b ov=%b r=%h f=%b required 0 1 %h %b",
                             c, ir, ov, r, f, held_r, held_f);
                end
            end
        end
        checks++;
        if (idx != 2) begin
            failures++;
            $display("FAIL bp_accepts: accepted=%0d required 2", idx);
        end
        for (int c = 0; c < 40 && (idx < 3 || sbq.size() != 0); c++) begin
            if (idx < 3) step(1'b1, ops[idx], as[idx], bs[idx], 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            else         step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            if (ak) idx++;
            if (cs) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra: unexpected result %h", r);
                end else begin
                    exp_t e = sbq.pop_front();
                    if (r !== e.res || f !== e.flg) begin
                        failures++;
                        $display("FAIL bp_order: result=%h flags=%b required %h %b", r, f, e.res, e.flg);
                    end
                end
            end
        end
        checks++;
        if (idx != 3 || sbq.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: issued=%0d pending=%0d required 3 0", idx, sbq.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        int stale = 0;
        step(1'b1, OP_ADD, 8'h20, 8'h01, 1'b0, 1'b1, 1'b0, ak, cs, ov, ir, r, f, ac);
        step(1'b1, OP_OR,  8'h40, 8'h02, 1'b0, 1'b1, 1'b0, ak, cs, ov, ir, r, f, ac);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ak, cs, ov, ir, r, f, ac);
        checks++;
        if (ov !== 1'b1 || ac === 8'h00) begin
            failures++;
            $display("FAIL rst_prefill: ov=%b acc=%h required 1 nonzero", ov, ac);
        end
        rst = 1'b1;
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ak, cs, ov, ir, r, f, ac);
        step(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
        checks++;
        if (ov !== 1'b0 || ac !== 8'h00 || ir !== 1'b0) begin
            failures++;
            $display("FAIL rst_midflight: ov=%b acc=%h in_ready=%b required 0 00 0", ov, ac, ir);
        end
        sbq.delete();
        macc = '0;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ak, cs, ov, ir, r, f, ac);
            if (cs) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rst_stale: stale outputs=%0d required 0", stale);
        end
    endtask

    task automatic test_random();
        logic ak, cs, ov, ir; logic [7:0] r, ac; logic [3:0] f;
        int idx = 0;
        for (int c = 0; c < 2000 && (idx < 60 || sbq.size() != 0); c++) begin
            logic iv = (idx < 60) && ($urandom_range(3, 0) != 0);
            logic ordy = ($urandom_range(9, 0) < 7);
            step(iv, 3'($urandom_range(7, 0)), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), ordy, ak, cs, ov, ir, r, f, ac);
            if (ak) idx++;
            if (cs) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra: unexpected result %h", r);
                end else begin
                    exp_t e = sbq.pop_front();
                    if (r !== e.res || f !== e.flg || ac !== e.acc) begin
                        failures++;
                        $display("FAIL rnd_result: result=%h flags=%b acc=%h required %h %b %h",
                                 r, f, ac, e.res, e.flg, e.acc);
                    end
                end
            end
        end
        checks++;
        if (idx != 60 || sbq.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain: issued=%0d pending=%0d required 60 0", idx, sbq.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.use_acc = 1'b0; bus.acc_wr = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_vectors();
        test_acc_chain();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 4..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 op  input  3  opcode: ADD=000, SUB=001, AND=010, OR=011, NAND=100, NOR=101, XOR=110, XNOR=111.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 use_acc  input  1  replace operand A with the internal accumulator.
REQ-010 acc_wr  input  1  write this operation's result into the accumulator.
REQ-011 out_valid  output  1  result/flags valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 result  output  WIDTH  operation result.
REQ-014 flags  output  4  {carry, overflow, negative, zero}.
REQ-015 acc  output  WIDTH  current accumulator value.

Function
REQ-016 Transfer rule: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-017 Two registered stages: S1 captures op/a/b/use_acc/acc_wr; S2 holds result/flags.
REQ-018 Computation is performed on the S1->S2 transfer; S2 advances when S1 is full && (!out_valid || out_ready).
REQ-019 in_ready = !S1_full || S2 advances this cycle (combinational from out_ready; no other combinational input-to-output paths).
REQ-020 Latency 2 cycles accept-to-out_valid with no backpressure; throughput 1 op/cycle sustained.
REQ-021 Under backpressure, result/flags SHALL hold stable while out_valid && !out_ready; no operation is dropped or duplicated.
REQ-022 Effective A = acc if use_acc, else S1 a; acc sampled at the S1->S2 transfer, so it reflects every earlier acc_wr op (no hazard).
REQ-023 On S1->S2 transfer with acc_wr=1, acc <= result in the same edge that loads S2.
REQ-024 ADD: result = (A+B) mod 2^WIDTH; carry = carry-out bit WIDTH.
REQ-025 SUB: result = (A-B) mod 2^WIDTH; carry = 1 iff A<B unsigned (borrow).
REQ-026 overflow: ADD/SUB signed two's-complement overflow; 0 for logic ops.
REQ-027 Logic ops bitwise per opcode name; carry=0, overflow=0.
REQ-028 zero = (result==0); negative = result[WIDTH-1]; both for all ops.

Reset
REQ-029 On rst: S1/S2 empty, out_valid=0, in_ready=0 while rst high, result=0, flags=0, acc=0.
REQ-030 Reset mid-operation discards all in-flight ops; no output produced for them.
REQ-031 First cycle after rst deasserts: in_ready=1.

Structure
REQ-032 Shared package pipe_alu_pkg: opcode constants, flag bit indices (carry=3, overflow=2, negative=1, zero=0), WIDTH default.
REQ-033 One combinational sub-module alu_core (WIDTH-parametrised: op, a, b -> result, flags), instanced between S1 and S2.

Verification (WIDTH=8)
REQ-034 ADD a=0xFF b=0x01, out_ready=1 -> 2 cycles later result=0x00, flags carry=1 overflow=0 zero=1 negative=0.
REQ-035 SUB a=0x80 b=0x01 -> result=0x7F, overflow=1, carry=0; SUB a=0x01 b=0x02 -> result=0xFF, carry=1, negative=1.
REQ-036 OR a=0xA0 b=0x05 -> 0xA5; NAND 0xFF,0xFF -> 0x00 zero=1; XNOR 0x0F,0xF0 -> 0x00.
REQ-037 Accumulate chain: ADD 0+5 acc_wr=1, then back-to-back ADD use_acc b=3 acc_wr=1 twice -> results 5,8,11; acc=11; no bubbles.
REQ-038 Backpressure: out_ready=0 for 5 cycles while issuing 3 ops -> in_ready drops after S1 fills; on out_ready=1, results appear in order, none lost or repeated, held stable while stalled.
REQ-039 Assert rst with both stages full -> next cycle out_valid=0, acc=0, in_ready=0; no stale result emitted afterwards.
